// File: rtl/field_editor_if.sv
// Bus between the display FSM / RTC muxes and the field_editor value-editing stage.
interface field_editor_if;
  logic [1:0] edit_mode;
  logic [1:0] edit_pos;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] cur_a;
  logic [7:0] cur_b;
  logic [7:0] cur_c;
  logic [7:0] val_a;
  logic [7:0] val_b;
  logic [7:0] val_c;
  logic       editing;
  logic       wr_strobe;
  logic [1:0] wr_group;

  modport master (
    output edit_mode, edit_pos, btn_up, btn_down, cur_a, cur_b, cur_c,
    input  val_a, val_b, val_c, editing, wr_strobe, wr_group
  );

  modport slave (
    input  edit_mode, edit_pos, btn_up, btn_down, cur_a, cur_b, cur_c,
    output val_a, val_b, val_c, editing, wr_strobe, wr_group
  );
endinterface

// File: rtl/field_editor.sv
// Edits the hour/timer/date register group with range-correct wrap and a
// one-cycle commit strobe on leaving a group.
module field_editor (
  input  logic          clk,
  input  logic          reset,
  field_editor_if.slave bus
);
  localparam int unsigned VW = 8;
  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] IDLE = 2'b00;
  localparam logic [SW-1:0] LOAD = 2'b01;
  localparam logic [SW-1:0] EDIT = 2'b10;

  localparam logic [1:0] GRP_IDLE = 2'b00;
  localparam logic [1:0] GRP_DATE = 2'b10;

  localparam logic [1:0] POS_A = 2'b11;
  localparam logic [1:0] POS_B = 2'b10;
  localparam logic [1:0] POS_C = 2'b01;

  logic [SW-1:0] state, state_n;
  logic [1:0]    grp, grp_n;
  logic [VW-1:0] val_a, val_b, val_c;
  logic [VW-1:0] val_a_n, val_b_n, val_c_n;
  logic          editing, editing_n;
  logic          wr_strobe, wr_strobe_n;
  logic [1:0]    wr_group, wr_group_n;

  logic          up_s, up_d, dn_s, dn_d;
  logic          press_up, press_dn;

  logic [VW-1:0] san_a, san_b, san_c;
  logic [VW-1:0] ed_a, ed_b, ed_c;
  logic          is_date;

  // Days in month; out-of-range months fall back to 31.
  function automatic logic [VW-1:0] dmax(input logic [VW-1:0] month,
                                         input logic [VW-1:0] year);
    case (month)
      8'd4, 8'd6, 8'd9, 8'd11: dmax = 8'd30;
      8'd2:                    dmax = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
      default:                 dmax = 8'd31;
    endcase
  endfunction

  // One wrap-around step; comparisons use >=/<= so stray values still wrap.
  function automatic logic [VW-1:0] step(input logic [VW-1:0] v,
                                         input logic [VW-1:0] lo,
                                         input logic [VW-1:0] hi,
                                         input logic          up);
    if (up) step = (v >= hi) ? lo : VW'(v + 8'd1);
    else    step = (v <= lo) ? hi : VW'(v - 8'd1);
  endfunction

  assign is_date  = (grp == GRP_DATE);
  assign press_up = up_s & ~up_d;
  assign press_dn = dn_s & ~dn_d;

  // Sanitised capture of the RTC read mux for the latched group.
  always_comb begin
    logic [VW-1:0] m, y, dm;
    m     = 8'd0;
    y     = 8'd0;
    dm    = 8'd0;
    san_a = bus.cur_a;
    san_b = bus.cur_b;
    san_c = bus.cur_c;
    if (is_date) begin
      m     = (bus.cur_b == 8'd0) ? 8'd1 : ((bus.cur_b > 8'd12) ? 8'd12 : bus.cur_b);
      y     = (bus.cur_c > 8'd99) ? 8'd99 : bus.cur_c;
      dm    = dmax(m, y);
      san_a = (bus.cur_a == 8'd0) ? 8'd1 : ((bus.cur_a > dm) ? dm : bus.cur_a);
      san_b = m;
      san_c = y;
    end else begin
      san_a = (bus.cur_a > 8'd23) ? 8'd23 : bus.cur_a;
      san_b = (bus.cur_b > 8'd59) ? 8'd59 : bus.cur_b;
      san_c = (bus.cur_c > 8'd59) ? 8'd59 : bus.cur_c;
    end
  end

  // Value after one press on the selected field, with day re-clamped for dates.
  always_comb begin
    logic [VW-1:0] dm;
    ed_a = val_a;
    ed_b = val_b;
    ed_c = val_c;
    dm   = 8'd0;
    case (bus.edit_pos)
      POS_A:   ed_a = step(val_a, is_date ? 8'd1 : 8'd0,
                           is_date ? dmax(val_b, val_c) : 8'd23, press_up);
      POS_B:   ed_b = step(val_b, is_date ? 8'd1 : 8'd0,
                           is_date ? 8'd12 : 8'd59, press_up);
      POS_C:   ed_c = step(val_c, 8'd0, is_date ? 8'd99 : 8'd59, press_up);
      default: ;
    endcase
    if (is_date) begin
      dm = dmax(ed_b, ed_c);
      if (ed_a > dm) ed_a = dm;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state;
    grp_n       = grp;
    val_a_n     = val_a;
    val_b_n     = val_b;
    val_c_n     = val_c;
    editing_n   = editing;
    wr_strobe_n = 1'b0;
    wr_group_n  = wr_group;
    case (state)
      IDLE: begin
        if (bus.edit_mode != GRP_IDLE) begin
          state_n = LOAD;
          grp_n   = bus.edit_mode;
        end
      end
      LOAD: begin
        val_a_n   = san_a;
        val_b_n   = san_b;
        val_c_n   = san_c;
        editing_n = 1'b1;
        state_n   = EDIT;
      end
      EDIT: begin
        if (bus.edit_mode == GRP_IDLE) begin
          state_n     = IDLE;
          editing_n   = 1'b0;
          wr_strobe_n = 1'b1;
          wr_group_n  = grp;
        end else if (bus.edit_mode != grp) begin
          state_n     = LOAD;
          grp_n       = bus.edit_mode;
          editing_n   = 1'b0;
          wr_strobe_n = 1'b1;
          wr_group_n  = grp;
        end else if ((bus.edit_pos != 2'b00) && (press_up ^ press_dn)) begin
          val_a_n = ed_a;
          val_b_n = ed_b;
          val_c_n = ed_c;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, outputs and button edge detectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grp       <= GRP_IDLE;
      val_a     <= 8'd0;
      val_b     <= 8'd0;
      val_c     <= 8'd0;
      editing   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_group  <= 2'b00;
      up_s      <= 1'b1;
      up_d      <= 1'b1;
      dn_s      <= 1'b1;
      dn_d      <= 1'b1;
    end else begin
      state     <= state_n;
      grp       <= grp_n;
      val_a     <= val_a_n;
      val_b     <= val_b_n;
      val_c     <= val_c_n;
      editing   <= editing_n;
      wr_strobe <= wr_strobe_n;
      wr_group  <= wr_group_n;
      up_s      <= bus.btn_up;
      up_d      <= up_s;
      dn_s      <= bus.btn_down;
      dn_d      <= dn_s;
    end
  end

  assign bus.val_a     = val_a;
  assign bus.val_b     = val_b;
  assign bus.val_c     = val_c;
  assign bus.editing   = editing;
  assign bus.wr_strobe = wr_strobe;
  assign bus.wr_group  = wr_group;
endmodule
